// File: rtl/fm0_tx_encoder.sv
// -----------------------------------------------------------------------------
// fm0_tx_encoder
// Backscatter reply encoder. It pulls data bits from a bit-serial source,
// prepends an optional 12-bit pilot tone and the FM0 preamble, appends the
// dummy-1 terminator and drives the FM0 modulator line.
//
// Parameters
//   HALF_DIV : clk cycles per FM0 half-bit (2..255)
//   MAX_BITS : data-bit limit before the reply is forcibly terminated
//
// Ports
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   start    : one-cycle reply request, ignored while busy
//   trext    : pilot-tone request, captured together with start
//   bitin    : current data bit from the source
//   bitdone  : high while bitin is the last data bit
//   bitclk   : one-cycle advance pulse to the source
//   txout    : FM0 modulator drive
//   busy     : reply in progress (through the done cycle)
//   done     : one-cycle end-of-reply pulse
//   overrun  : with done, when the reply hit MAX_BITS
// -----------------------------------------------------------------------------
module fm0_tx_encoder #(
    parameter int HALF_DIV = 4,
    parameter int MAX_BITS = 128
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic trext,
    input  logic bitin,
    input  logic bitdone,
    output logic bitclk,
    output logic txout,
    output logic busy,
    output logic done,
    output logic overrun
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRIME    = 3'd1,
        PILOT    = 3'd2,
        PREAMBLE = 3'd3,
        DATA     = 3'd4,
        DUMMY    = 3'd5,
        FINISH   = 3'd6
    } state_t;

    localparam logic [7:0]  HALF_END     = 8'(HALF_DIV - 1);
    localparam logic [7:0]  BIT_LIMIT    = 8'(MAX_BITS);
    // Preamble half-bits, first half in the MSB ("1 0 1 0 v 1").
    localparam logic [11:0] PREAMBLE_PAT = 12'b1101_0010_0011;

    // Half-bit level of the preamble at position idx (0 = first half).
    function automatic logic preamble_half(input logic [3:0] idx);
        logic [11:0] shifted;
        shifted = PREAMBLE_PAT << idx;
        return shifted[11];
    endfunction

    state_t      state_r;
    logic [7:0]  timer_r;
    logic [4:0]  half_idx_r;
    logic        level_r;
    logic        txout_r;
    logic        bitclk_r;
    logic        busy_r;
    logic        done_r;
    logic        overrun_r;
    logic        trext_r;
    logic        bit_r;
    logic        last_r;
    logic        ovf_flag_r;
    logic [7:0]  bit_cnt_r;

    logic        half_end_s;
    logic        bit_limit_s;
    logic [7:0]  bit_cnt_inc_s;
    logic        pre_next_s;

    assign half_end_s    = (timer_r == HALF_END);
    assign bit_limit_s   = (bit_cnt_r >= BIT_LIMIT);
    assign bit_cnt_inc_s = (bit_cnt_r == 8'hFF) ? 8'hFF : (bit_cnt_r + 8'd1);
    assign pre_next_s    = preamble_half(half_idx_r[3:0] + 4'd1);

    assign bitclk  = bitclk_r;
    assign txout   = txout_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign overrun = overrun_r;

    // Reply sequencer: state, half-bit timing, level tracking and all outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            timer_r    <= 8'd0;
            half_idx_r <= 5'd0;
            level_r    <= 1'b0;
            txout_r    <= 1'b0;
            bitclk_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overrun_r  <= 1'b0;
            trext_r    <= 1'b0;
            bit_r      <= 1'b0;
            last_r     <= 1'b0;
            ovf_flag_r <= 1'b0;
            bit_cnt_r  <= 8'd0;
        end else begin
            bitclk_r  <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    txout_r <= 1'b0;
                    busy_r  <= 1'b0;
                    if (start) begin
                        trext_r    <= trext;
                        bitclk_r   <= 1'b1;
                        busy_r     <= 1'b1;
                        bit_cnt_r  <= 8'd0;
                        ovf_flag_r <= 1'b0;
                        state_r    <= PRIME;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PRIME: begin
                    // Both the pilot and the preamble open with a high half-bit.
                    timer_r    <= 8'd0;
                    half_idx_r <= 5'd0;
                    level_r    <= 1'b1;
                    txout_r    <= 1'b1;
                    state_r    <= trext_r ? PILOT : PREAMBLE;
                end
                PILOT: begin
                    if (half_end_s) begin
                        timer_r <= 8'd0;
                        if (half_idx_r == 5'd23) begin
                            half_idx_r <= 5'd0;
                            level_r    <= 1'b1;
                            txout_r    <= 1'b1;
                            state_r    <= PREAMBLE;
                        end else begin
                            half_idx_r <= half_idx_r + 5'd1;
                            level_r    <= ~level_r;
                            txout_r    <= ~level_r;
                        end
                    end else begin
                        timer_r <= timer_r + 8'd1;
                    end
                end
                PREAMBLE: begin
                    if (half_end_s) begin
                        timer_r <= 8'd0;
                        if (half_idx_r == 5'd11) begin
                            // First data bit: sample the source on this edge.
                            bit_r      <= bitin;
                            last_r     <= bitdone;
                            bitclk_r   <= ~bitdone;
                            bit_cnt_r  <= bit_cnt_inc_s;
                            half_idx_r <= 5'd0;
                            level_r    <= ~level_r;
                            txout_r    <= ~level_r;
                            state_r    <= DATA;
                        end else begin
                            half_idx_r <= half_idx_r + 5'd1;
                            level_r    <= pre_next_s;
                            txout_r    <= pre_next_s;
                        end
                    end else begin
                        timer_r <= timer_r + 8'd1;
                    end
                end
                DATA: begin
                    if (half_end_s) begin
                        timer_r <= 8'd0;
                        if (!half_idx_r[0]) begin
                            // Mid-bit: a 0 toggles, a 1 holds.
                            half_idx_r <= 5'd1;
                            level_r    <= bit_r ? level_r : ~level_r;
                            txout_r    <= bit_r ? level_r : ~level_r;
                        end else if (last_r || bit_limit_s) begin
                            ovf_flag_r <= ~last_r;
                            half_idx_r <= 5'd0;
                            level_r    <= ~level_r;
                            txout_r    <= ~level_r;
                            state_r    <= DUMMY;
                        end else begin
                            bit_r      <= bitin;
                            last_r     <= bitdone;
                            bitclk_r   <= ~bitdone;
                            bit_cnt_r  <= bit_cnt_inc_s;
                            half_idx_r <= 5'd0;
                            level_r    <= ~level_r;
                            txout_r    <= ~level_r;
                        end
                    end else begin
                        timer_r <= timer_r + 8'd1;
                    end
                end
                DUMMY: begin
                    if (half_end_s) begin
                        timer_r <= 8'd0;
                        if (!half_idx_r[0]) begin
                            // Dummy bit is a 1: second half holds the level.
                            half_idx_r <= 5'd1;
                        end else begin
                            half_idx_r <= 5'd0;
                            txout_r    <= 1'b0;
                            done_r     <= 1'b1;
                            overrun_r  <= ovf_flag_r;
                            state_r    <= FINISH;
                        end
                    end else begin
                        timer_r <= timer_r + 8'd1;
                    end
                end
                FINISH: begin
                    timer_r    <= 8'd0;
                    txout_r    <= 1'b0;
                    level_r    <= 1'b0;
                    busy_r     <= 1'b0;
                    ovf_flag_r <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    txout_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fm0_tx_encoder.sv
// -----------------------------------------------------------------------------
// tb_fm0_tx_encoder
// Two encoder instances: a short one (HALF_DIV=2, MAX_BITS=4) and a long one
// (HALF_DIV=4, MAX_BITS=128). A behavioural bit source feeds the selected one;
// every reply pushes its expected per-cycle output vector into a queue that a
// negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_fm0_tx_encoder;

    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic trext;
    logic bitin;
    logic bitdone;
    logic use_long;

    logic start_a, bitclk_a, txout_a, busy_a, done_a, overrun_a;
    logic start_b, bitclk_b, txout_b, busy_b, done_b, overrun_b;
    logic bitclk_s, txout_s, busy_s, done_s, overrun_s;
    logic [4:0] obs_s;

    int tests_run = 0;
    int tests_failed = 0;

    logic [4:0] exp_q[$];
    bit         stream[0:255];
    int         src_cnt = 0;
    int         src_base = 0;
    int         src_len = 0;
    bit         src_has_done = 1'b0;

    always #5 clk = ~clk;

    assign start_a  = start & ~use_long;
    assign start_b  = start & use_long;
    assign bitclk_s = use_long ? bitclk_b  : bitclk_a;
    assign txout_s  = use_long ? txout_b   : txout_a;
    assign busy_s   = use_long ? busy_b    : busy_a;
    assign done_s   = use_long ? done_b    : done_a;
    assign overrun_s = use_long ? overrun_b : overrun_a;
    assign obs_s    = {txout_s, bitclk_s, busy_s, done_s, overrun_s};

    fm0_tx_encoder #(.HALF_DIV(2), .MAX_BITS(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .trext(trext),
        .bitin(bitin), .bitdone(bitdone), .bitclk(bitclk_a), .txout(txout_a),
        .busy(busy_a), .done(done_a), .overrun(overrun_a)
    );

    fm0_tx_encoder #(.HALF_DIV(4), .MAX_BITS(128)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .trext(trext),
        .bitin(bitin), .bitdone(bitdone), .bitclk(bitclk_b), .txout(txout_b),
        .busy(busy_b), .done(done_b), .overrun(overrun_b)
    );

    // Bit source: advances on each rising edge of bitclk; the first edge
    // (PRIME) presents bit 0.
    always @(posedge bitclk_s) src_cnt <= src_cnt + 1;

    always_comb begin
        int idx;
        idx = src_cnt - src_base - 1;
        bitin = 1'b0;
        bitdone = 1'b0;
        if (idx >= 0 && idx < 256) bitin = stream[idx];
        if (src_has_done && idx == src_len - 1) bitdone = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0h, want %0h", tag, $time, obs, exp);
        end
    endtask

    // Scoreboard monitor: one expected output vector per clock cycle.
    always @(negedge clk) begin
        logic [4:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("wave{tx,bclk,busy,done,ovr}", {27'd0, obs_s}, {27'd0, e});
        end
    end

    // Runs one reply on the selected instance. restart pulses start during
    // busy; abort_c>0 pulls reset at that cycle of the reply.
    task automatic run_reply(input bit long_i, input bit trext_i, input int len,
                             input bit has_done, input bit restart, input int abort_c);
        int hd, maxb, nh, p, n, f, clk_exp, clk_obs, done_c, done_seen, h, k;
        bit halves[0:511];
        bit obs_half[0:511];
        bit lvl, ovr, ended_by_done, tx, bc;
        logic [11:0] pre;
        hd = long_i ? 4 : 2;
        maxb = long_i ? 128 : 4;
        pre = 12'b1101_0010_0011;
        nh = 0;
        lvl = 1'b0;
        if (trext_i) begin
            for (int i = 0; i < 24; i++) begin
                lvl = (i % 2 == 0);
                halves[nh] = lvl; nh = nh + 1;
            end
        end
        for (int i = 0; i < 12; i++) begin
            lvl = pre[11 - i];
            halves[nh] = lvl; nh = nh + 1;
        end
        p = nh;
        ended_by_done = has_done && (len <= maxb);
        n = ended_by_done ? len : maxb;
        ovr = ~ended_by_done;
        for (int i = 0; i < n; i++) begin
            lvl = ~lvl; halves[nh] = lvl; nh = nh + 1;
            if (!stream[i]) lvl = ~lvl;
            halves[nh] = lvl; nh = nh + 1;
        end
        lvl = ~lvl; halves[nh] = lvl; nh = nh + 1;
        halves[nh] = lvl; nh = nh + 1;
        f = 2 + hd * nh;
        clk_exp = 1 + n - (ended_by_done ? 1 : 0);

        src_base = src_cnt;
        src_len = len;
        src_has_done = has_done;
        @(negedge clk);
        start = 1'b1;
        trext = trext_i;
        @(posedge clk);
        for (int c = 1; c <= f + 1; c++) begin
            tx = (c >= 2 && c < f) ? halves[(c - 2) / hd] : 1'b0;
            bc = (c == 1);
            if (c >= 2 && c < f && ((c - 2) % hd) == 0) begin
                h = (c - 2) / hd;
                if (h >= p && ((h - p) % 2) == 0) begin
                    k = (h - p) / 2;
                    if (k < n && !(ended_by_done && k == len - 1)) bc = 1'b1;
                end
            end
            exp_q.push_back({tx, bc, (c <= f), (c == f), ((c == f) && ovr)});
        end
        #1;
        start = 1'b0;
        trext = ~trext_i;

        clk_obs = 0;
        done_c = -1;
        for (int c = 1; c <= f + 1; c++) begin
            @(negedge clk);
            if (c == abort_c) begin
                #2;
                reset_n = 1'b0;
                exp_q.delete();
                #1;
                check_eq("reset_abort_outputs", {27'd0, obs_s}, 32'd0);
                repeat (3) begin
                    @(negedge clk);
                    check_eq("reset_hold_outputs", {27'd0, obs_s}, 32'd0);
                end
                reset_n = 1'b1;
                done_seen = 0;
                repeat (f) begin
                    @(negedge clk);
                    if (done_s || busy_s) done_seen++;
                end
                check_eq("no_done_after_abort", done_seen, 0);
                start = 1'b0;
                return;
            end
            start = restart && (c == 10 || c == f);
            if (c >= 2 && c < f && ((c - 2) % hd) == hd / 2) obs_half[(c - 2) / hd] = txout_s;
            if (bitclk_s) clk_obs++;
            if (done_s) done_c = c;
        end
        start = 1'b0;
        @(posedge clk);
        check_eq("queue_drained", exp_q.size(), 0);
        check_eq("done_cycle", done_c, f);
        check_eq("bitclk_count", clk_obs, clk_exp);
        for (int i = 0; i < n; i++)
            check_eq("fm0_decode", obs_half[p + 2 * i] == obs_half[p + 2 * i + 1], stream[i]);
        check_eq("dummy_decode", obs_half[p + 2 * n] == obs_half[p + 2 * n + 1], 1);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        trext = 1'b0;
        use_long = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_state_a", {27'd0, txout_a, bitclk_a, busy_a, done_a, overrun_a}, 32'd0);
        check_eq("reset_state_b", {27'd0, txout_b, bitclk_b, busy_b, done_b, overrun_b}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic reply: bits 1,0, bitdone on the second.
        stream[0] = 1'b1; stream[1] = 1'b0;
        run_reply(1'b0, 1'b0, 2, 1'b1, 1'b0, 0);
        // Pilot tone with a single 0 bit.
        stream[0] = 1'b0;
        run_reply(1'b0, 1'b1, 1, 1'b1, 1'b0, 0);
        // start during busy and in the FINISH cycle must be ignored.
        stream[0] = 1'b1; stream[1] = 1'b0;
        run_reply(1'b0, 1'b0, 2, 1'b1, 1'b1, 0);
        // Reset during DATA, then a complete reply.
        run_reply(1'b0, 1'b0, 2, 1'b1, 1'b0, 28);
        repeat (2) @(negedge clk);
        run_reply(1'b0, 1'b0, 2, 1'b1, 1'b0, 0);
        // Overrun: bitdone never asserted, limit is 4 bits.
        for (int i = 0; i < 8; i++) stream[i] = 1'($urandom_range(0, 1));
        run_reply(1'b0, 1'b0, 8, 1'b0, 1'b0, 0);
        // Long reply on the HALF_DIV=4 instance.
        use_long = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 96; i++) stream[i] = 1'($urandom_range(0, 1));
        run_reply(1'b1, 1'b0, 96, 1'b1, 1'b0, 0);
        // Short pilot reply on the long instance.
        for (int i = 0; i < 5; i++) stream[i] = 1'($urandom_range(0, 1));
        run_reply(1'b1, 1'b1, 5, 1'b1, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
